// File: rtl/seg7_ascii_capture_if.sv
// Display read-back bundle: the five active-low segment buses and rescan request
// going in, the decoded character stream with its status flags coming out.
interface seg7_ascii_capture_if;
   logic [6:0] hex_seg4;
   logic [6:0] hex_seg3;
   logic [6:0] hex_seg2;
   logic [6:0] hex_seg1;
   logic [6:0] hex_seg0;
   logic       rescan;
   logic       char_ready;
   logic [7:0] char_out;
   logic       char_valid;
   logic [2:0] char_idx;
   logic       unknown;
   logic       busy;

   modport slave (
      input  hex_seg4, hex_seg3, hex_seg2, hex_seg1, hex_seg0,
      input  rescan, char_ready,
      output char_out, char_valid, char_idx, unknown, busy
   );

   modport master (
      output hex_seg4, hex_seg3, hex_seg2, hex_seg1, hex_seg0,
      output rescan, char_ready,
      input  char_out, char_valid, char_idx, unknown, busy
   );
endinterface

// File: rtl/seg7_ascii_capture.sv
// Samples the five 7-segment buses, waits for them to settle, and streams each new
// settled message out as five ASCII bytes, leftmost digit first.
module seg7_ascii_capture #(
   parameter int unsigned STABLE_CYCLES = 4
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   seg7_ascii_capture_if.slave  cap_if
);
   typedef enum logic [1:0] {ST_SETTLE, ST_EMIT, ST_DONE} state_e;

   localparam logic [7:0]  CNT_MAX       = 8'(STABLE_CYCLES - 1);
   localparam logic [7:0]  ASCII_UNKNOWN = 8'h3F;
   localparam logic [34:0] ALL_BLANK     = '1;

   function automatic logic [7:0] seg_decode(input logic [6:0] seg);
      logic [7:0] ch;
      case (seg)
         7'h40:   ch = 8'h30;
         7'h79:   ch = 8'h31;
         7'h24:   ch = 8'h32;
         7'h30:   ch = 8'h33;
         7'h19:   ch = 8'h34;
         7'h12:   ch = 8'h35;
         7'h02:   ch = 8'h36;
         7'h78:   ch = 8'h37;
         7'h00:   ch = 8'h38;
         7'h10:   ch = 8'h39;
         7'h09:   ch = 8'h48;
         7'h06:   ch = 8'h45;
         7'h04:   ch = 8'h65;
         7'h47:   ch = 8'h4C;
         7'h4F:   ch = 8'h6C;
         7'h23:   ch = 8'h6F;
         7'h0C:   ch = 8'h50;
         7'h2B:   ch = 8'h4E;
         7'h7F:   ch = 8'h20;
         default: ch = ASCII_UNKNOWN;
      endcase
      return ch;
   endfunction

   logic [34:0]     raw_seg;
   logic [34:0]     sync1_q, sync2_q, prev_q;
   logic [7:0]      cnt_q, cnt_d;
   logic [4:0][6:0] snap_q, snap_d;
   logic [34:0]     last_q, last_d;
   logic [2:0]      idx_q, idx_d;
   state_e          state_q, state_d;
   logic            rescan_q, rescan_d;
   logic            unknown_q, unknown_d;
   logic            same, settled;
   logic [7:0]      cur_char;

   assign raw_seg  = {cap_if.hex_seg4, cap_if.hex_seg3, cap_if.hex_seg2,
                      cap_if.hex_seg1, cap_if.hex_seg0};
   assign same     = (sync2_q == prev_q);
   assign settled  = same && (cnt_q == CNT_MAX);
   assign cur_char = seg_decode(snap_q[idx_q]);

   // Segment buses come from another clock domain; two flops before any compare.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync1_q <= ALL_BLANK;
         sync2_q <= ALL_BLANK;
         prev_q  <= ALL_BLANK;
      end else begin
         sync1_q <= raw_seg;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= ST_SETTLE;
         cnt_q     <= '0;
         snap_q    <= ALL_BLANK;
         last_q    <= ALL_BLANK;
         idx_q     <= 3'd4;
         rescan_q  <= 1'b0;
         unknown_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         snap_q    <= snap_d;
         last_q    <= last_d;
         idx_q     <= idx_d;
         rescan_q  <= rescan_d;
         unknown_q <= unknown_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      snap_d    = snap_q;
      last_d    = last_q;
      idx_d     = idx_q;
      rescan_d  = rescan_q | cap_if.rescan;
      unknown_d = unknown_q;

      if (!same) begin
         cnt_d = '0;
      end else if (cnt_q != CNT_MAX) begin
         cnt_d = cnt_q + 8'd1;
      end

      case (state_q)
         ST_SETTLE: begin
            if (settled && ((sync2_q != last_q) || rescan_q)) begin
               snap_d   = sync2_q;
               last_d   = sync2_q;
               rescan_d = cap_if.rescan;
               idx_d    = 3'd4;
               state_d  = ST_EMIT;
            end
         end
         ST_EMIT: begin
            if (cap_if.char_ready) begin
               // First byte of a message starts a fresh Unknown verdict.
               if (idx_q == 3'd4) begin
                  unknown_d = (cur_char == ASCII_UNKNOWN);
               end else if (cur_char == ASCII_UNKNOWN) begin
                  unknown_d = 1'b1;
               end
               if (idx_q == 3'd0) begin
                  state_d = ST_DONE;
               end else begin
                  idx_d = idx_q - 3'd1;
               end
            end
         end
         ST_DONE: begin
            cnt_d   = '0;
            state_d = ST_SETTLE;
         end
         default: state_d = ST_SETTLE;
      endcase
   end

   assign cap_if.char_valid = (state_q == ST_EMIT);
   assign cap_if.char_out   = (state_q == ST_EMIT) ? cur_char : 8'h00;
   assign cap_if.char_idx   = idx_q;
   assign cap_if.unknown    = unknown_q;
   assign cap_if.busy       = (state_q == ST_EMIT);
endmodule

// File: tb/tb_seg7_ascii_capture.sv
// Scoreboard bench: each driven display pushes its expected byte stream, a
// negedge monitor pops and compares every accepted byte.
module tb_seg7_ascii_capture;
   logic clk;
   logic rst_n;
   int   errors = 0;
   int   checks = 0;
   int   xfer_count = 0;

   logic [10:0] sb[$];
   logic        exp_unk = 1'b0;
   logic        unk_pending = 1'b0;
   logic        hold_pending = 1'b0;
   logic [7:0]  hold_out = 8'h00;
   logic [2:0]  hold_idx = 3'd0;

   seg7_ascii_capture_if bus();

   seg7_ascii_capture #(.STABLE_CYCLES(4)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .cap_if (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic set_display(input logic [6:0] d4, input logic [6:0] d3, input logic [6:0] d2,
                              input logic [6:0] d1, input logic [6:0] d0);
      bus.hex_seg4 = d4;
      bus.hex_seg3 = d3;
      bus.hex_seg2 = d2;
      bus.hex_seg1 = d1;
      bus.hex_seg0 = d0;
   endtask

   task automatic push_msg(input logic [7:0] c4, input logic [7:0] c3, input logic [7:0] c2,
                           input logic [7:0] c1, input logic [7:0] c0);
      sb.push_back({3'd4, c4});
      sb.push_back({3'd3, c3});
      sb.push_back({3'd2, c2});
      sb.push_back({3'd1, c1});
      sb.push_back({3'd0, c0});
   endtask

   task automatic push_hello();
      push_msg(8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F);
   endtask

   task automatic set_hello();
      set_display(7'h09, 7'h04, 7'h4F, 7'h4F, 7'h23);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drain(input string tag, input bit toggle);
      bit done = 1'b0;
      for (int c = 0; c < 200; c++) begin
         @(posedge clk);
         #1;
         bus.char_ready = toggle ? ~bus.char_ready : 1'b1;
         if (sb.size() == 0 && !bus.char_valid) begin
            done = 1'b1;
            break;
         end
      end
      check(tag, done, 1);
      bus.char_ready = 1'b1;
   endtask

   // Monitor: one line per accepted byte, Unknown checked the cycle after.
   always @(negedge clk) begin
      logic [10:0] e;
      if (!rst_n) begin
         hold_pending = 1'b0;
         unk_pending  = 1'b0;
         exp_unk      = 1'b0;
      end else begin
         if (unk_pending) begin
            check("unknown", bus.unknown, exp_unk);
            unk_pending = 1'b0;
         end
         if (hold_pending && bus.char_valid) begin
            check("hold_char", bus.char_out, hold_out);
            check("hold_idx", bus.char_idx, hold_idx);
         end
         hold_pending = bus.char_valid && !bus.char_ready;
         hold_out     = bus.char_out;
         hold_idx     = bus.char_idx;
         if (bus.char_valid && bus.char_ready) begin
            xfer_count++;
            $display("xfer idx=%0d char=0x%02h", bus.char_idx, bus.char_out);
            if (sb.size() == 0) begin
               check("unexpected_xfer", 1, 0);
            end else begin
               e = sb.pop_front();
               check("char", bus.char_out, e[7:0]);
               check("idx", bus.char_idx, e[10:8]);
               if (e[10:8] == 3'd4) exp_unk = (e[7:0] == 8'h3F);
               else if (e[7:0] == 8'h3F) exp_unk = 1'b1;
               unk_pending = 1'b1;
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int base;
      bit found;

      rst_n = 1'b0;
      set_display(7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
      bus.char_ready = 1'b1;
      bus.rescan     = 1'b0;
      idle(3);
      check("rst_valid", bus.char_valid, 0);
      check("rst_out", bus.char_out, 8'h00);
      check("rst_idx", bus.char_idx, 3'd4);
      check("rst_unknown", bus.unknown, 0);
      check("rst_busy", bus.busy, 0);
      rst_n = 1'b1;
      idle(12);
      check("blank_no_emit", xfer_count, 0);

      // Hello with ready held high, measure latency from input change
      set_hello();
      push_hello();
      n = 0;
      for (int c = 1; c <= 30; c++) begin
         @(posedge clk);
         @(negedge clk);
         if (bus.char_valid) begin
            n = c;
            break;
         end
      end
      check("latency", n, 7);
      check("busy_emit", bus.busy, 1);
      drain("drain_hello", 1'b0);
      base = xfer_count;
      idle(30);
      check("hello_no_repeat", xfer_count - base, 0);

      // NP with a stalling consumer
      set_display(7'h2B, 7'h0C, 7'h7F, 7'h7F, 7'h7F);
      push_msg(8'h4E, 8'h50, 8'h20, 8'h20, 8'h20);
      drain("drain_np", 1'b1);

      // Rescan re-emits an unchanged display exactly once
      set_hello();
      push_hello();
      drain("drain_hello2", 1'b0);
      idle(10);
      bus.rescan = 1'b1;
      idle(1);
      bus.rescan = 1'b0;
      push_hello();
      drain("drain_rescan", 1'b0);
      base = xfer_count;
      idle(30);
      check("rescan_once", xfer_count - base, 0);

      // Short glitch returning to the last message emits nothing
      bus.hex_seg2 = 7'h00;
      idle(2);
      bus.hex_seg2 = 7'h4F;
      idle(30);
      check("glitch_no_emit", xfer_count - base, 0);

      // Undecodable pattern -> '?', Unknown set; next good message clears it
      bus.hex_seg0 = 7'h55;
      push_msg(8'h48, 8'h65, 8'h6C, 8'h6C, 8'h3F);
      drain("drain_unknown", 1'b0);
      check("unknown_set", bus.unknown, 1);
      set_hello();
      push_hello();
      drain("drain_clear", 1'b0);
      check("unknown_clear", bus.unknown, 0);

      // Reset while idx 2 is presented
      set_display(7'h79, 7'h24, 7'h30, 7'h19, 7'h12);
      push_msg(8'h31, 8'h32, 8'h33, 8'h34, 8'h35);
      found = 1'b0;
      for (int c = 0; c < 50; c++) begin
         @(posedge clk);
         #1;
         if (bus.char_valid && bus.char_idx == 3'd2) begin
            found = 1'b1;
            break;
         end
      end
      check("reached_idx2", found, 1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", bus.char_valid, 0);
      check("mid_rst_out", bus.char_out, 8'h00);
      check("mid_rst_idx", bus.char_idx, 3'd4);
      check("mid_rst_busy", bus.busy, 0);
      check("mid_rst_unknown", bus.unknown, 0);
      sb.delete();
      set_hello();
      idle(3);
      rst_n = 1'b1;
      push_hello();
      drain("drain_after_rst", 1'b0);
      base = xfer_count;
      idle(20);
      check("after_rst_once", xfer_count - base, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
